shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
//
// PURPOSE
//  Iterative unsigned multiplier built on the left-shift datapath. It drives the
//  logical shift-left stage: each cycle it shifts the multiplicand left by one bit
//  and conditionally accumulates it. It takes one operand pair per start pulse and
//  returns the full-width product after L2 iterations. It is the multiply unit for
//  ALU paths where area matters more than latency.
//
// PARAMETERS
//  L1  8  width of multiplicand in1 (bits)
//  L2  8  width of multiplier in2 (bits); also the iteration count
//
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only when busy==0
//  in1    in   L1     multiplicand (unsigned), sampled with accepted start
//  in2    in   L2     multiplier (unsigned), sampled with accepted start
//  busy   out  1      high while iterating; start ignored while high
//  done   out  1      single-cycle pulse: out holds a new product
//  out    out  L1+L2  product register; holds last product until next done
//
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, busy=0, done=0, out=0, internal regs=0.
//    rst has priority over all other inputs, including mid-operation (abort, no done).
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> load mcand={L2'b0,in1}, mplier=in2, acc=0, cnt=0; go RUN.
//    RUN : each cycle: if mplier[0] acc<=acc+mcand; mcand<=mcand<<1;
//          mplier<=mplier>>1; cnt<=cnt+1. After the L2-th iteration -> DONE,
//          out<=final acc (accumulator incl. last add), done pulses in DONE cycle.
//    DONE: done=1, busy=0. start=1 here is accepted exactly as in IDLE (-> RUN),
//          enabling back-to-back operations; else -> IDLE.
//  - busy=1 iff state==RUN. start while busy is dropped, not queued; operands
//    captured at acceptance, so in1/in2 may change freely afterwards.
//  - Latency: start accepted at edge t -> RUN for L2 cycles -> done high in the
//    cycle after edge t+L2 (i.e. observed at edge t+L2+1). Fixed, data-independent.
//  - Widths: all arithmetic unsigned, L1+L2 bits; acc cannot overflow
//    (max (2^L1-1)(2^L2-1) < 2^(L1+L2)). Bits shifted beyond L1+L2 are discarded.
//    cnt width = clog2(L2+1).
//  - out changes only on the DONE transition or reset; stable otherwise.
//  - done is never high for two consecutive cycles unless a new op completes,
//    which needs >= L2+1 cycles, so done is always a clean pulse.
//  - Zero operands: still runs full L2 cycles, product 0.
//
// TESTING (L1=L2=8 unless stated)
//  1. start, in1=5, in2=3 -> busy 8 cycles, done pulse at t+9, out=16'd15.
//  2. in1=255, in2=255 -> out=16'd65025 (0xFE01), no overflow.
//  3. in1=0, in2=200 then in1=200, in2=0 -> out=0 both, each full 8-cycle latency.
//  4. start with 7*9, re-assert start with 2*2 at cycle t+3 -> ignored; out=63 only.
//  5. rst=1 at cycle t+4 of 12*12 -> next cycle busy=0, done=0, out=0; no done later;
//     fresh start 3*4 then yields out=12.
//  6. start held high continuously with 6*7 then 10*10 in DONE cycle -> done pulses
//     at t+9 (out=42) and t+18 (out=100); L1=4,L2=12: 15*4095 -> out=61425.

Source files
------------

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one multiplicand shift and
// conditional accumulate per cycle, full L1+L2-bit product after L2 cycles.
module shift_add_mult #(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [L1-1:0]    in1,
  input  logic [L2-1:0]    in2,
  output logic             busy,
  output logic             done,
  output logic [L1+L2-1:0] out
);
  localparam int W  = L1 + L2;
  localparam int CW = $clog2(L2 + 1);
  localparam logic [CW-1:0] LAST = CW'(L2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    mcand, acc, sum;
  logic [L2-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            load, last;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign load = start && (state != RUN);
  assign last = (cnt == LAST);
  // accumulator including this cycle's partial product
  assign sum  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mcand  <= W'(in1);
        mplier <= in2;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) out <= sum;
      end
    end
  end
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed plus randomized checks of shift_add_mult against plain a*b products,
// with cycle-exact busy/done/out expectations.
module tb_shift_add_mult;
  localparam int L2 = 8;

  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  in1 = 0, in2 = 0;
  logic        busy, done;
  logic [15:0] out;

  logic        start_b = 0;
  logic [3:0]  in1_b = 0;
  logic [11:0] in2_b = 0;
  logic        busy_b, done_b;
  logic [15:0] out_b;

  int n = 0, errs = 0;
  logic [15:0] last_out = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.L1(8), .L2(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out));

  shift_add_mult #(.L1(4), .L2(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in1(in1_b), .in2(in2_b),
    .busy(busy_b), .done(done_b), .out(out_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s);
    @(negedge clk);
    start = s; in1 = 8'($urandom); in2 = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1; in1 = a; in2 = b;
    @(posedge clk); #1;
    chk("accept_busy", busy, 1); chk("accept_done", done, 0);
  endtask

  task automatic run(input int cycles, input logic hold, input int inj);
    for (int i = 1; i <= cycles; i++) begin
      step(hold || (i == inj));
      chk("run_busy", busy, 1); chk("run_done", done, 0);
      chk("run_out_stable", out, last_out);
    end
  endtask

  task automatic finish_op(input logic [15:0] exp);
    chk("done_pulse", done, 1); chk("done_busy", busy, 0);
    chk("product", out, exp);
    last_out = exp;
  endtask

  task automatic mul(input logic [7:0] a, input logic [7:0] b, input int inj);
    accept(a, b);
    run(L2 - 1, 0, inj);
    step(0);
    finish_op(16'(int'(a) * int'(b)));
    step(0);
    chk("idle_done", done, 0); chk("idle_busy", busy, 0);
    chk("idle_out", out, last_out);
  endtask

  task automatic mul_b(input logic [3:0] a, input logic [11:0] b);
    int lat;
    @(negedge clk);
    start_b = 1; in1_b = a; in2_b = b;
    @(posedge clk); #1;
    @(negedge clk);
    start_b = 0; in1_b = 4'($urandom); in2_b = 12'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done_b && lat < 40);
    chk("b_latency", lat, 12);
    chk("b_product", out_b, int'(a) * int'(b));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_out", out, 0);
    chk("rst_b_out", out_b, 0);
    @(negedge clk); rst = 0;

    mul(5, 3, -1);
    mul(255, 255, -1);
    mul(0, 200, -1);
    mul(200, 0, -1);
    // start during RUN must be dropped
    @(negedge clk); in1 = 2; in2 = 2;
    mul(7, 9, 3);

    // abort mid-operation with reset
    accept(12, 12);
    run(3, 0, -1);
    @(negedge clk); start = 0; rst = 1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_out", out, 0);
    @(negedge clk); rst = 0;
    last_out = 0;
    for (int i = 0; i < L2 + 3; i++) begin
      step(0);
      chk("abort_no_done", done, 0); chk("abort_out_hold", out, 0);
    end
    mul(3, 4, -1);

    // back-to-back with start held high
    accept(6, 7);
    run(L2 - 1, 1, -1);
    step(1);
    finish_op(42);
    @(negedge clk); start = 1; in1 = 10; in2 = 10;
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1); chk("b2b_done", done, 0);
    run(L2 - 1, 1, -1);
    step(0);
    finish_op(100);
    step(0);
    chk("b2b_idle_done", done, 0);

    for (int k = 0; k < 20; k++) mul(8'($urandom), 8'($urandom), (k % 3 == 0) ? 5 : -1);

    mul_b(15, 4095);
    for (int k = 0; k < 8; k++) mul_b(4'($urandom), 12'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
